// File: rtl/trigger_in_filter.sv
// External trigger conditioning: synchronise, glitch-filter, edge-select, fixed pulse plus holdoff, with accept/reject counters.
// Optional build macro TRIG_IN_TIMESTAMP_EN latches a free-running cycle count on each accepted edge.
module trigger_in_filter #(
  parameter int SYNC_STAGES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trig_pin,
  input  logic        reg_trig_in_enable,
  input  logic [1:0]  reg_edge_sel,
  input  logic [31:0] reg_filter_width,
  input  logic [31:0] reg_pulse_width,
  input  logic [31:0] reg_holdoff,
  input  logic        reg_cnt_clear,
  output logic        trigger_out,
  output logic        busy,
  output logic [31:0] trig_accept_cnt,
  output logic [31:0] trig_reject_cnt,
  output logic [31:0] trig_timestamp
);

  typedef enum logic [1:0] {IDLE, PULSE, HOLDOFF} state_t;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   filt;
  logic                   filt_d;
  logic [31:0]            stab_cnt;
  logic [31:0]            filt_w;
  logic [31:0]            pulse_w;
  logic [31:0]            hold_w;
  logic [31:0]            p_cnt;
  logic [31:0]            h_cnt;
  logic [31:0]            h_load;
  logic                   rise;
  logic                   fall;
  logic                   qual;
  logic                   qual_r;
  logic                   accept;
  logic                   reject;

  assign sync    = sync_q[SYNC_STAGES-1];
  assign filt_w  = (reg_filter_width == 32'd0) ? 32'd1 : reg_filter_width;
  assign pulse_w = (reg_pulse_width == 32'd0) ? 32'd1 : reg_pulse_width;
  assign hold_w  = (reg_holdoff < 32'd3) ? 32'd3 : reg_holdoff;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], trig_pin};
    end
  end

  // A new level must hold for W consecutive cycles before filt follows it.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt     <= 1'b0;
      filt_d   <= 1'b0;
      stab_cnt <= '0;
    end else begin
      filt_d <= filt;
      if (sync != filt) begin
        if (stab_cnt == filt_w - 32'd1) begin
          filt     <= sync;
          stab_cnt <= '0;
        end else begin
          stab_cnt <= stab_cnt + 32'd1;
        end
      end else begin
        stab_cnt <= '0;
      end
    end
  end

  assign rise = filt & ~filt_d;
  assign fall = ~filt & filt_d;

  always_comb begin
    qual = 1'b0;
    case (reg_edge_sel)
      2'b00:   qual = rise;
      2'b01:   qual = fall;
      2'b10:   qual = rise | fall;
      default: qual = 1'b0;
    endcase
    qual = qual & reg_trig_in_enable;
  end

  // One register stage on the qualified edge sets the pin-to-output latency at SYNC_STAGES+W+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      qual_r <= 1'b0;
    end else begin
      qual_r <= qual;
    end
  end

  assign accept = qual_r && (state == IDLE);
  assign reject = qual_r && (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      trigger_out <= 1'b0;
      busy        <= 1'b0;
      p_cnt       <= '0;
      h_cnt       <= '0;
      h_load      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (qual_r) begin
            state       <= PULSE;
            trigger_out <= 1'b1;
            busy        <= 1'b1;
            p_cnt       <= pulse_w - 32'd1;
            h_load      <= hold_w - 32'd1;
          end
        end
        PULSE: begin
          if (p_cnt == 32'd0) begin
            state       <= HOLDOFF;
            trigger_out <= 1'b0;
            h_cnt       <= h_load;
          end else begin
            p_cnt <= p_cnt - 32'd1;
          end
        end
        HOLDOFF: begin
          if (h_cnt == 32'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            h_cnt <= h_cnt - 32'd1;
          end
        end
        default: begin
          state       <= IDLE;
          trigger_out <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

  // Counters only assign when their value changes; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst || reg_cnt_clear) begin
      trig_accept_cnt <= '0;
    end else if (accept && trig_accept_cnt != CNT_MAX) begin
      trig_accept_cnt <= trig_accept_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || reg_cnt_clear) begin
      trig_reject_cnt <= '0;
    end else if (reject && trig_reject_cnt != CNT_MAX) begin
      trig_reject_cnt <= trig_reject_cnt + 32'd1;
    end
  end

`ifdef TRIG_IN_TIMESTAMP_EN
  logic [31:0] cycle_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt      <= '0;
      trig_timestamp <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (accept) begin
        trig_timestamp <= cycle_cnt;
      end
    end
  end
`else
  assign trig_timestamp = '0;
`endif

endmodule

// File: tb/tb_trigger_in_filter.sv
// Directed bench for trigger_in_filter: latency, glitch rejection, holdoff, counter limits, reset and config mid-pulse.
module tb_trigger_in_filter;

  logic        clk;
  logic        rst;
  logic        trig_pin;
  logic        reg_trig_in_enable;
  logic [1:0]  reg_edge_sel;
  logic [31:0] reg_filter_width;
  logic [31:0] reg_pulse_width;
  logic [31:0] reg_holdoff;
  logic        reg_cnt_clear;
  logic        trigger_out;
  logic        busy;
  logic [31:0] trig_accept_cnt;
  logic [31:0] trig_reject_cnt;
  logic [31:0] trig_timestamp;

  int n_tests = 0;
  int n_fail  = 0;
  int low_run = 100;
  int rise_cnt = 0;
  logic prev_to = 1'b0;

  trigger_in_filter #(.SYNC_STAGES(3)) dut (
    .clk                (clk),
    .rst                (rst),
    .trig_pin           (trig_pin),
    .reg_trig_in_enable (reg_trig_in_enable),
    .reg_edge_sel       (reg_edge_sel),
    .reg_filter_width   (reg_filter_width),
    .reg_pulse_width    (reg_pulse_width),
    .reg_holdoff        (reg_holdoff),
    .reg_cnt_clear      (reg_cnt_clear),
    .trigger_out        (trigger_out),
    .busy               (busy),
    .trig_accept_cnt    (trig_accept_cnt),
    .trig_reject_cnt    (trig_reject_cnt),
    .trig_timestamp     (trig_timestamp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock, sample just after the edge, and check the low gap ahead of every rise.
  task automatic tick;
    @(posedge clk);
    #1;
    if (trigger_out && !prev_to) begin
      rise_cnt++;
      chk("gap_before_rise", (low_run >= 3) ? 32'd1 : 32'd0, 32'd1);
    end
    low_run = trigger_out ? 0 : low_run + 1;
    prev_to = trigger_out;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    trig_pin = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Tick n times; report edge index (0 = pin-capture edge) of first high sample and high length.
  task automatic measure(input int n, output int rise_edge, output int len);
    rise_edge = -1;
    len = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (trigger_out) begin
        if (rise_edge < 0) rise_edge = i - 1;
        len++;
      end
    end
  endtask

  int re, ln, r0, hi;

  initial begin
    trig_pin           = 1'b0;
    reg_trig_in_enable = 1'b1;
    reg_edge_sel       = 2'b00;
    reg_filter_width   = 32'd1;
    reg_pulse_width    = 32'd1;
    reg_holdoff        = 32'd3;
    reg_cnt_clear      = 1'b0;
    rst                = 1'b1;

    do_reset();
    chk("rst_trigger_out", {31'd0, trigger_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_accept", trig_accept_cnt, 32'd0);
    chk("rst_reject", trig_reject_cnt, 32'd0);
    chk("rst_timestamp", trig_timestamp, 32'd0);

    // Rising edge, W=4: rise at edge 3+4+1 = 8, high for 10 cycles
    reg_filter_width = 32'd4;
    reg_pulse_width  = 32'd10;
    reg_holdoff      = 32'd5;
    trig_pin = 1'b1;
    measure(30, re, ln);
    chk("rise_latency", re, 32'd8);
    chk("rise_len", ln, 32'd10);
    chk("rise_accept", trig_accept_cnt, 32'd1);
    chk("rise_reject", trig_reject_cnt, 32'd0);
    trig_pin = 1'b0;
    repeat (20) tick();
    chk("fall_ignored", trig_accept_cnt, 32'd1);
    chk("rise_idle_busy", {31'd0, busy}, 32'd0);

    // Glitch filter, W=8: three 7-cycle pulses vanish, one 8-cycle pulse triggers
    do_reset();
    reg_filter_width = 32'd8;
    reg_pulse_width  = 32'd3;
    r0 = rise_cnt;
    repeat (3) begin
      trig_pin = 1'b1;
      repeat (7) tick();
      trig_pin = 1'b0;
      repeat (12) tick();
    end
    chk("glitch_rises", rise_cnt - r0, 32'd0);
    chk("glitch_accept", trig_accept_cnt, 32'd0);
    chk("glitch_reject", trig_reject_cnt, 32'd0);
    trig_pin = 1'b1;
    repeat (8) tick();
    trig_pin = 1'b0;
    repeat (30) tick();
    chk("w8_accept", trig_accept_cnt, 32'd1);
    chk("w8_rises", rise_cnt - r0, 32'd1);

    // Holdoff: both edges, P=2, H=0->3, busy span 5 cycles
    do_reset();
    reg_filter_width = 32'd1;
    reg_pulse_width  = 32'd2;
    reg_holdoff      = 32'd0;
    reg_edge_sel     = 2'b10;
    r0 = rise_cnt;
    for (int k = 0; k < 8; k++) begin
      trig_pin = ~trig_pin;
      repeat (3) tick();
    end
    repeat (20) tick();
    chk("hold3_accept", trig_accept_cnt, 32'd4);
    chk("hold3_reject", trig_reject_cnt, 32'd4);
    chk("hold3_rises", rise_cnt - r0, 32'd4);
    // Spacing 5 lands on the final holdoff cycle: reject, then accept
    for (int k = 0; k < 5; k++) begin
      trig_pin = ~trig_pin;
      repeat (5) tick();
    end
    repeat (20) tick();
    chk("hold5_accept", trig_accept_cnt, 32'd7);
    chk("hold5_reject", trig_reject_cnt, 32'd6);

    // Counter saturation
    do_reset();
    reg_pulse_width = 32'd1;
    reg_holdoff     = 32'd3;
    reg_edge_sel    = 2'b10;
    force dut.trig_accept_cnt = 32'hFFFF_FFFF;
    force dut.trig_reject_cnt = 32'hFFFF_FFFF;
    tick();
    release dut.trig_accept_cnt;
    release dut.trig_reject_cnt;
    trig_pin = 1'b1;
    tick();
    tick();
    trig_pin = 1'b0;
    repeat (15) tick();
    chk("sat_rises_seen", {31'd0, (rise_cnt > 0)}, 32'd1);
    chk("sat_accept", trig_accept_cnt, 32'hFFFF_FFFF);
    chk("sat_reject", trig_reject_cnt, 32'hFFFF_FFFF);

    // Clear on the accept edge wins
    reg_edge_sel = 2'b00;
    trig_pin = 1'b1;
    repeat (5) tick();
    reg_cnt_clear = 1'b1;
    tick();
    reg_cnt_clear = 1'b0;
    chk("clr_trigger_out", {31'd0, trigger_out}, 32'd1);
    chk("clr_accept", trig_accept_cnt, 32'd0);
    chk("clr_reject", trig_reject_cnt, 32'd0);
    trig_pin = 1'b0;
    repeat (10) tick();
    trig_pin = 1'b1;
    repeat (15) tick();
    chk("post_clr_accept", trig_accept_cnt, 32'd1);

    // Reset at PULSE cycle 3 of P=10
    do_reset();
    reg_pulse_width = 32'd10;
    reg_holdoff     = 32'd5;
    trig_pin = 1'b1;
    repeat (8) tick();
    chk("pre_rst_high", {31'd0, trigger_out}, 32'd1);
    chk("pre_rst_accept", trig_accept_cnt, 32'd1);
    rst = 1'b1;
    trig_pin = 1'b0;
    tick();
    chk("midrst_trigger_out", {31'd0, trigger_out}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_accept", trig_accept_cnt, 32'd0);
    rst = 1'b0;
    repeat (20) tick();
    chk("midrst_quiet", trig_accept_cnt, 32'd0);

    // Config change mid-pulse keeps the latched P=4
    reg_pulse_width = 32'd4;
    reg_holdoff     = 32'd3;
    trig_pin = 1'b1;
    repeat (6) tick();
    chk("cfg_high", {31'd0, trigger_out}, 32'd1);
    chk("cfg_busy", {31'd0, busy}, 32'd1);
    reg_pulse_width    = 32'd20;
    reg_trig_in_enable = 1'b0;
    reg_edge_sel       = 2'b11;
    hi = 1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (trigger_out) hi++;
    end
    chk("cfg_len", hi, 32'd4);
    chk("cfg_idle", {31'd0, busy}, 32'd0);
    chk("cfg_accept", trig_accept_cnt, 32'd1);
`ifndef TRIG_IN_TIMESTAMP_EN
    chk("timestamp_const", trig_timestamp, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
